// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported memory between the fetch (IF) and
//               load/store (MA) stages and stalls whichever stage is not
//               being served. Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//               (round-robin tie break instead of fixed MA priority).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IF_READ,
  input  logic [ADDR_WIDTH-1:0] IF_ADDR,
  output logic [DATA_WIDTH-1:0] IF_DATA,
  output logic                  IF_BUSYWAIT,
  input  logic [3:0]            MA_READ,
  input  logic [2:0]            MA_WRITE,
  input  logic [ADDR_WIDTH-1:0] MA_ADDR,
  input  logic [DATA_WIDTH-1:0] MA_WRITEDATA,
  output logic [DATA_WIDTH-1:0] MA_READDATA,
  output logic                  MA_BUSYWAIT,
  output logic [3:0]            MEM_READ,
  output logic [2:0]            MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  localparam logic       c_own_if   = 1'b0;
  localparam logic       c_own_ma   = 1'b1;
  localparam logic [3:0] c_if_read  = 4'b1010;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_read;
  logic [2:0]            r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_if_data;
  logic [DATA_WIDTH-1:0] r_ma_readdata;

  logic w_ma_req;
  logic w_if_req;
  logic w_grant;
  logic w_grant_ma;

  assign w_ma_req = MA_READ[3] | MA_WRITE[2];
  assign w_if_req = IF_READ;
  assign w_grant  = w_ma_req | w_if_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On a tie the stage that was not granted last goes first.
  assign w_grant_ma = w_ma_req & (~w_if_req | (r_last_grant == c_own_if));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_grant <= c_own_if;
    end else if ((r_state == c_st_idle) && w_grant) begin
      r_last_grant <= w_grant_ma ? c_own_ma : c_own_if;
    end
  end
`else
  assign w_grant_ma = w_ma_req;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (w_grant) w_next_state = c_st_issue;
      c_st_issue: w_next_state = c_st_wait;
      c_st_wait:  if (!MEM_BUSYWAIT) w_next_state = c_st_resp;
      c_st_resp:  w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_owner       <= c_own_if;
      r_addr        <= '0;
      r_read        <= '0;
      r_write       <= '0;
      r_wdata       <= '0;
      r_if_data     <= '0;
      r_ma_readdata <= '0;
    end else begin
      if ((r_state == c_st_idle) && w_grant) begin
        if (w_grant_ma) begin
          r_owner <= c_own_ma;
          r_addr  <= MA_ADDR;
          r_read  <= MA_READ;
          // A combined load+store request is treated as the load alone.
          r_write <= MA_READ[3] ? 3'b000 : MA_WRITE;
          r_wdata <= MA_WRITEDATA;
        end else begin
          r_owner <= c_own_if;
          r_addr  <= IF_ADDR;
          r_read  <= c_if_read;
          r_write <= 3'b000;
          r_wdata <= '0;
        end
      end
      // Read data of a withdrawn requester is dropped.
      if ((r_state == c_st_wait) && !MEM_BUSYWAIT && r_read[3]) begin
        if ((r_owner == c_own_ma) && w_ma_req) r_ma_readdata <= MEM_READDATA;
        if ((r_owner == c_own_if) && w_if_req) r_if_data     <= MEM_READDATA;
      end
    end
  end

  always_comb begin
    MEM_READ      = 4'b0000;
    MEM_WRITE     = 3'b000;
    if ((r_state == c_st_issue) || (r_state == c_st_wait)) begin
      MEM_READ  = r_read;
      MEM_WRITE = r_write;
    end
    MEM_ADDR      = r_addr;
    MEM_WRITEDATA = r_wdata;
    IF_BUSYWAIT   = w_if_req & ~((r_state == c_st_resp) && (r_owner == c_own_if));
    MA_BUSYWAIT   = w_ma_req & ~((r_state == c_st_resp) && (r_owner == c_own_ma));
  end

  assign IF_DATA     = r_if_data;
  assign MA_READDATA = r_ma_readdata;

endmodule
`default_nettype wire
